// File: rtl/disp_arb_pkg.sv
// Shared types and helpers for the display arbiter: FSM states, blank pattern, digit bundle.
package disp_arb_pkg;

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  localparam logic [7:0] SSEG_BLANK = 8'hFF;
  localparam int         MAX_N      = 8;

  typedef logic [3:0][7:0] digits_t;

  function automatic logic [MAX_N-1:0] onehot(input logic [2:0] idx);
    logic [MAX_N-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/disp_arbiter_if.sv
// Requester-facing and display-facing bundle of the arbiter; the arbiter uses the slave side.
interface disp_arbiter_if #(
  parameter int N = 4
);
  logic [N-1:0]    req;
  logic [N*32-1:0] data;
  logic [N-1:0]    gnt;
  logic [7:0]      in0;
  logic [7:0]      in1;
  logic [7:0]      in2;
  logic [7:0]      in3;
  logic            busy;

  modport master (output req, data, input gnt, in0, in1, in2, in3, busy);
  modport slave  (input req, data, output gnt, in0, in1, in2, in3, busy);
endinterface

// File: rtl/disp_arbiter_rr_pick.sv
// Round-robin search: first requester after `last` (with wrap), optionally skipping one index.
module rr_pick #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  input  logic          exclude_en,
  input  logic [IW-1:0] exclude_idx,
  output logic          found,
  output logic [IW-1:0] idx
);

  always_comb begin : search
    int          cand;
    logic [IW-1:0] ci;
    found = 1'b0;
    idx   = '0;
    cand  = 0;
    ci    = '0;
    for (int k = 1; k <= N; k++) begin
      cand = (int'(last) + k) % N;
      ci   = IW'(cand);
      if (!found && req[ci] && !(exclude_en && (ci == exclude_idx))) begin
        found = 1'b1;
        idx   = ci;
      end
    end
  end

endmodule

// File: rtl/disp_arbiter.sv
// Round-robin display arbiter with minimum dwell; DISP_ARB_PRIORITY_EN makes requester 0 a
// preempting alarm channel that is never rotated away.
module disp_arbiter
  import disp_arb_pkg::*;
#(
  parameter int N     = 4,
  parameter int DWELL = 50_000_000
) (
  input  logic           clk,
  input  logic           reset,
  disp_arbiter_if.slave  bus
);

  localparam int            IW      = $clog2(N);
  localparam int            CW      = $clog2(DWELL);
  localparam logic [CW-1:0] CNT_MAX = CW'(DWELL - 1);

  state_t        state, state_n;
  logic [N-1:0]  gnt, gnt_n;
  logic [IW-1:0] owner, owner_n;
  logic [IW-1:0] last, last_n;
  logic [CW-1:0] count, count_n;

  logic          excl_en;
  logic          found;
  logic [IW-1:0] pick;
  logic          preempt;
  logic          rotate_ok;
  logic [MAX_N-1:0] oh;

  // While holding, the current owner is never a rotation/handoff candidate.
  assign excl_en = (state == HOLD);

  rr_pick #(.N(N)) u_pick (
    .req         (bus.req),
    .last        (last),
    .exclude_en  (excl_en),
    .exclude_idx (owner),
    .found       (found),
    .idx         (pick)
  );

`ifdef DISP_ARB_PRIORITY_EN
  assign preempt   = (state == HOLD) && bus.req[0] && (owner != '0);
  assign rotate_ok = (owner != '0);
`else
  assign preempt   = 1'b0;
  assign rotate_ok = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      gnt   <= '0;
      owner <= '0;
      last  <= IW'(N - 1);
      count <= '0;
    end else begin
      state <= state_n;
      gnt   <= gnt_n;
      owner <= owner_n;
      last  <= last_n;
      count <= count_n;
    end
  end

  always_comb begin
    state_n = state;
    owner_n = owner;
    last_n  = last;
    count_n = count;
    case (state)
      IDLE: begin
        if (found) begin
          state_n = HOLD;
          owner_n = pick;
          last_n  = pick;
          count_n = '0;
        end
      end
      HOLD: begin
        count_n = (count == CNT_MAX) ? count : count + 1'b1;
        if (preempt) begin
          // Alarm takes over without touching `last`, so rotation resumes afterwards.
          owner_n = '0;
          count_n = '0;
        end else if (!bus.req[owner]) begin
          if (found) begin
            owner_n = pick;
            last_n  = pick;
            count_n = '0;
          end else begin
            state_n = IDLE;
            count_n = '0;
          end
        end else if ((count == CNT_MAX) && found && rotate_ok) begin
          owner_n = pick;
          last_n  = pick;
          count_n = '0;
        end
      end
      default: state_n = IDLE;
    endcase
    oh    = onehot(3'(owner_n));
    gnt_n = (state_n == HOLD) ? oh[N-1:0] : '0;
  end

  digits_t slots [N];
  digits_t cur;

  for (genvar g = 0; g < N; g++) begin : g_slot
    assign slots[g] = bus.data[32*g +: 32];
  end

  assign cur      = slots[owner];
  assign bus.gnt  = gnt;
  assign bus.busy = |gnt;
  assign bus.in0  = (state == HOLD) ? cur[0] : SSEG_BLANK;
  assign bus.in1  = (state == HOLD) ? cur[1] : SSEG_BLANK;
  assign bus.in2  = (state == HOLD) ? cur[2] : SSEG_BLANK;
  assign bus.in3  = (state == HOLD) ? cur[3] : SSEG_BLANK;

endmodule

// File: tb/tb_disp_arbiter.sv
// Directed scoreboard bench for disp_arbiter (N=4, DWELL=8); the preemption steps follow
// DISP_ARB_PRIORITY_EN.
module tb_disp_arbiter;

  localparam int N     = 4;
  localparam int DWELL = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] d [N];

  int vectors     = 0;
  int miscompares = 0;

  logic [36:0] exp_q [$];
  string       tag_q [$];

  disp_arbiter_if #(.N(N)) dif ();

  disp_arbiter #(.N(N), .DWELL(DWELL)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (dif.slave)
  );

  always #5 clk = ~clk;

  assign dif.data = {d[3], d[2], d[1], d[0]};

  // Expected gnt/busy/digits derived from the bench's own data table.
  task automatic push_exp(input string tag, input logic [3:0] eg);
    logic [31:0] digs;
    case (eg)
      4'b0001: digs = d[0];
      4'b0010: digs = d[1];
      4'b0100: digs = d[2];
      4'b1000: digs = d[3];
      default: digs = 32'hFFFF_FFFF;
    endcase
    exp_q.push_back({eg, |eg, digs});
    tag_q.push_back(tag);
  endtask

  task automatic pop_cmp();
    logic [36:0] got, e;
    string       t;
    got = {dif.gnt, dif.busy, dif.in3, dif.in2, dif.in1, dif.in0};
    e   = exp_q.pop_front();
    t   = tag_q.pop_front();
    vectors++;
    assert (got === e) else begin
      miscompares++;
      $error("FAIL %s: observed gnt/busy/digits %h, expected %h", t, got, e);
    end
  endtask

  task automatic cyc(input string tag, input logic [3:0] eg);
    @(posedge clk);
    #1;
    push_exp(tag, eg);
    pop_cmp();
  endtask

  initial begin
    d[0]    = 32'hC0F9A4B0;
    d[1]    = 32'h11223344;
    d[2]    = 32'h99929282;
    d[3]    = 32'hA1B2C3D4;
    reset   = 1'b1;
    dif.req = 4'b1111;

    cyc("reset_a", 4'b0000);
    cyc("reset_b", 4'b0000);
    reset = 1'b0;
    cyc("first_grant", 4'b0001);

    dif.req = 4'b0101;
    for (int j = 1; j <= 24; j++)
      cyc("rotate", ((j / 8) % 2 == 1) ? 4'b0100 : 4'b0001);

    d[2] = 32'h12345678;
    #1;
    push_exp("data_pass", 4'b0100);
    pop_cmp();

    dif.req = 4'b0010;
    cyc("handoff_1", 4'b0010);
    for (int j = 0; j <= 40; j++)
      cyc("lone_hold", 4'b0010);

    dif.req = 4'b0000;
    cyc("to_idle", 4'b0000);

    dif.req = 4'b0010;
    cyc("grant_1", 4'b0010);
    for (int j = 0; j < 3; j++)
      cyc("count_1", 4'b0010);
    dif.req = 4'b1000;
    cyc("drop_to_3", 4'b1000);

    dif.req = 4'b0010;
    cyc("back_to_1", 4'b0010);
    for (int j = 0; j < 3; j++)
      cyc("count_1b", 4'b0010);
    dif.req = 4'b0000;
    cyc("drop_blank", 4'b0000);

    dif.req = 4'b1000;
    cyc("grant_3", 4'b1000);
    for (int j = 0; j < 5; j++)
      cyc("count_3", 4'b1000);
    reset   = 1'b1;
    dif.req = 4'b1111;
    cyc("reset_mid", 4'b0000);
    cyc("reset_mid2", 4'b0000);
    reset = 1'b0;
    cyc("rr_zero_first", 4'b0001);
    for (int j = 1; j <= 8; j++)
      cyc("rr_then_one", (j < 8) ? 4'b0001 : 4'b0010);

    dif.req = 4'b0100;
    cyc("hold_2", 4'b0100);
    cyc("hold_2_c1", 4'b0100);
    dif.req = 4'b1101;
`ifdef DISP_ARB_PRIORITY_EN
    cyc("preempt", 4'b0001);
    for (int j = 0; j < 10; j++)
      cyc("prio_hold", 4'b0001);
    dif.req = 4'b1100;
    cyc("resume_3", 4'b1000);
    dif.req = 4'b0100;
    cyc("hold_2b", 4'b0100);
    dif.req = 4'b0101;
    cyc("preempt_b", 4'b0001);
    dif.req = 4'b0100;
    cyc("resume_2", 4'b0100);
`else
    cyc("no_preempt", 4'b0100);
    cyc("no_preempt2", 4'b0100);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
